// File: rtl/fpu_pkg.sv
// Shared types and FPU latency constants for the vector FPU sequencer.
package fpu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    DIV = 2'b10,
    MUL = 2'b11
  } fpu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } fpu_seq_state_t;

  localparam int unsigned FPU_LAT_ASM = 2;
  localparam int unsigned FPU_LAT_DIV = 17;

endpackage

// File: rtl/fpu_vec_sequencer_if.sv
// Issue-side and FPU-side signal bundle of the vector FPU sequencer.
interface fpu_vec_sequencer_if #(
   parameter int unsigned LANES = 8,
   parameter int unsigned LW    = $clog2(LANES + 1)
);
   import fpu_pkg::*;

   logic                  start;
   fpu_op_t               op;
   logic [LW-1:0]         vlen;
   logic [32*LANES-1:0]   vec_a;
   logic [32*LANES-1:0]   vec_b;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [32*LANES-1:0]   vec_o;
   logic                  fpu_enable;
   fpu_op_t               fpu_opcode;
   logic [31:0]           fpu_a;
   logic [31:0]           fpu_b;
   logic                  fpu_ready;
   logic [31:0]           fpu_o;

   modport master (
      input  start, op, vlen, vec_a, vec_b, fpu_ready, fpu_o,
      output busy, done, err, vec_o, fpu_enable, fpu_opcode, fpu_a, fpu_b
   );

   modport slave (
      output start, op, vlen, vec_a, vec_b, fpu_ready, fpu_o,
      input  busy, done, err, vec_o, fpu_enable, fpu_opcode, fpu_a, fpu_b
   );

endinterface

// File: rtl/fpu_seq_watchdog.sv
// Loadable up-counter with clear and enable; flags terminal count TIMEOUT-1.
module fpu_seq_watchdog #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          clear,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          enable,
   output logic          tc
);

   logic [CW-1:0] cnt_q;

   assign tc = (cnt_q == CW'(TIMEOUT - 1));

   // Saturates at terminal count so tc stays asserted until cleared or reloaded.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (enable && !tc) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/fpu_vec_sequencer.sv
// Walks a latched operand vector pair through the shared scalar FPU one element at a time.
module fpu_vec_sequencer
   import fpu_pkg::*;
#(
   parameter int unsigned LANES   = 8,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned LW      = $clog2(LANES + 1)
) (
   input logic                  CLK,
   input logic                  reset,
   fpu_vec_sequencer_if.master  bus
);

   localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef logic [LANES-1:0][31:0] vec_t;

   fpu_seq_state_t state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [LW-1:0]  len_q, len_d, len_sat;
   fpu_op_t        op_q, op_d;
   vec_t           a_q, a_d, b_q, b_d, res_q, res_d;
   logic           err_q, err_d, done_q, done_d, busy_q, busy_d, en_q, en_d;
   logic [31:0]    fa_q, fa_d, fb_q, fb_d;
   logic           accept, last, wd_tc;

   assign len_sat = (bus.vlen > LW'(LANES)) ? LW'(LANES) : bus.vlen;
   assign accept  = (state_q == IDLE) && bus.start;
   assign last    = (LW'(idx_q) == len_q - LW'(1));

   fpu_seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .CLK      (CLK),
      .reset    (reset),
      .clear    ((state_q == RUN) && bus.fpu_ready),
      .load     (accept),
      .load_val (CW'(0)),
      .enable   (state_q == RUN),
      .tc       (wd_tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      err_d   = err_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      en_d    = en_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d   = bus.op;
               a_d    = vec_t'(bus.vec_a);
               b_d    = vec_t'(bus.vec_b);
               len_d  = len_sat;
               res_d  = '0;
               idx_d  = '0;
               err_d  = 1'b0;
               busy_d = 1'b1;
               if (len_sat == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  en_d    = 1'b1;
                  fa_d    = bus.vec_a[31:0];
                  fb_d    = bus.vec_b[31:0];
               end
            end
         end
         RUN: begin
            if (bus.fpu_ready) begin
               res_d[idx_q] = bus.fpu_o;
               en_d         = 1'b0;
               if (last) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = GAP;
               end
            end else if (wd_tc) begin
               err_d   = 1'b1;
               en_d    = 1'b0;
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         // Enable low for one cycle clears the FPU's latency counter between elements.
         GAP: begin
            state_d = RUN;
            en_d    = 1'b1;
            fa_d    = a_q[idx_q];
            fb_d    = b_q[idx_q];
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         op_q    <= ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         en_q    <= en_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.vec_o      = res_q;
   assign bus.fpu_enable = en_q;
   assign bus.fpu_opcode = op_q;
   assign bus.fpu_a      = fa_q;
   assign bus.fpu_b      = fb_q;

endmodule

// File: tb/tb_fpu_vec_sequencer.sv
// Scoreboard bench for fpu_vec_sequencer with a behavioural FPU carrying the real ready latencies.
module tb_fpu_vec_sequencer;
   import fpu_pkg::*;

   localparam int unsigned LANES   = 8;
   localparam int unsigned TIMEOUT = 32;

   typedef logic [LANES-1:0][31:0] vec_t;

   typedef struct {
      vec_t        vec;
      int unsigned lat;
      int unsigned en_cycles;
      int unsigned gaps;
      logic        err;
   } exp_t;

   logic CLK;
   logic reset;
   logic stall;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];

   fpu_vec_sequencer_if #(.LANES(LANES)) bus ();

   fpu_vec_sequencer #(
      .LANES   (LANES),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- behavioural FPU ----------------
   function automatic real sp2real(input logic [31:0] v);
      logic [63:0] d;
      if (v[30:23] == 8'd0) return 0.0;
      d = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fpu_model(input fpu_op_t o, input logic [31:0] a,
                                             input logic [31:0] b);
      real ra, rb;
      ra = sp2real(a);
      rb = sp2real(b);
      case (o)
         ADD:     return real2sp(ra + rb);
         SUB:     return real2sp(ra - rb);
         MUL:     return real2sp(ra * rb);
         default: return real2sp(ra / rb);
      endcase
   endfunction

   int unsigned fcnt;
   int unsigned flat;
   assign flat = (bus.fpu_opcode == DIV) ? FPU_LAT_DIV : FPU_LAT_ASM;

   always @(posedge CLK or negedge bus.fpu_enable) begin
      if (!bus.fpu_enable) fcnt <= 0;
      else if (fcnt < flat) fcnt <= fcnt + 1;
   end

   assign bus.fpu_ready = !stall && bus.fpu_enable && (fcnt == flat);
   assign bus.fpu_o     = fpu_model(bus.fpu_opcode, bus.fpu_a, bus.fpu_b);

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_run(input vec_t v, input int unsigned n, input int unsigned lf);
      exp_t e;
      e.vec       = v;
      e.err       = 1'b0;
      e.en_cycles = n * (lf + 1);
      e.gaps      = (n == 0) ? 0 : n - 1;
      e.lat       = (n == 0) ? 1 : n * (lf + 1) + (n - 1) + 1;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge of the first cycle after the start edge.
   task automatic drive_start(input fpu_op_t o, input logic [3:0] n, input vec_t a,
                              input vec_t b);
      bus.op    = o;
      bus.vlen  = n;
      bus.vec_a = a;
      bus.vec_b = b;
      bus.start = 1'b1;
      @(negedge CLK);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit pulse_in_done);
      int unsigned c, en_c, gap_c;
      exp_t e;
      c = 1; en_c = 0; gap_c = 0;
      while (!bus.done && c < 200) begin
         if (bus.fpu_enable) en_c++;
         else gap_c++;
         @(negedge CLK);
         c++;
      end
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      check({tag, "_done"}, bus.done, 1'b1);
      check({tag, "_latency"}, c, e.lat);
      check({tag, "_vec_o"}, bus.vec_o, e.vec);
      check({tag, "_err"}, bus.err, e.err);
      check({tag, "_busy_in_done"}, bus.busy, 1'b1);
      check({tag, "_en_cycles"}, en_c, e.en_cycles);
      check({tag, "_gap_cycles"}, gap_c, e.gaps);
      check({tag, "_en_in_done"}, bus.fpu_enable, 1'b0);
      if (pulse_in_done) begin
         bus.op    = MUL;
         bus.vlen  = 4'd1;
         bus.start = 1'b1;
      end
      @(negedge CLK);
      bus.start = 1'b0;
      check({tag, "_busy_after"}, bus.busy, 1'b0);
      check({tag, "_done_after"}, bus.done, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vec_t a, b, ev;
      exp_t et;
      n_cmp = 0; n_err = 0;
      stall = 1'b0;
      reset = 1'b0;
      bus.start = 1'b0; bus.op = ADD; bus.vlen = '0; bus.vec_a = '0; bus.vec_b = '0;
      repeat (2) @(negedge CLK);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_vec_o", bus.vec_o, '0);
      check("rst_en", bus.fpu_enable, 1'b0);
      check("rst_opcode", bus.fpu_opcode, 2'b00);
      check("rst_fpu_a", bus.fpu_a, '0);
      check("rst_fpu_b", bus.fpu_b, '0);
      reset = 1'b1;
      @(negedge CLK);

      // ADD, two elements
      a = '0; b = '0; ev = '0;
      a[0] = 32'h3F800000; a[1] = 32'h40000000;
      b[0] = 32'h3F800000; b[1] = 32'h3F800000;
      ev[0] = 32'h40000000; ev[1] = 32'h40400000;
      expect_run(ev, 2, FPU_LAT_ASM);
      drive_start(ADD, 4'd2, a, b);
      wait_done("add2", 1'b0);

      // DIV, one element
      a = '0; b = '0; ev = '0;
      a[0] = 32'h40C00000; b[0] = 32'h40000000; ev[0] = 32'h40400000;
      expect_run(ev, 1, FPU_LAT_DIV);
      drive_start(DIV, 4'd1, a, b);
      wait_done("div1", 1'b0);

      // SUB, with a MUL start pulsed during its done cycle (must be ignored)
      a = '0; b = '0; ev = '0;
      a[0] = 32'h40400000; b[0] = 32'h3F800000; ev[0] = 32'h40000000;
      expect_run(ev, 1, FPU_LAT_ASM);
      drive_start(SUB, 4'd1, a, b);
      wait_done("sub1", 1'b1);
      @(negedge CLK);
      check("ignored_start_busy", bus.busy, 1'b0);
      check("ignored_start_vec_o", bus.vec_o, ev);

      a = '0; b = '0; ev = '0;
      a[0] = 32'h3FC00000; b[0] = 32'h40000000; ev[0] = 32'h40400000;
      expect_run(ev, 1, FPU_LAT_ASM);
      drive_start(MUL, 4'd1, a, b);
      wait_done("mul1", 1'b0);

      // Zero length
      expect_run('0, 0, FPU_LAT_ASM);
      drive_start(ADD, 4'd0, a, b);
      wait_done("len0", 1'b0);

      // Over-length saturates to LANES
      a = '0; b = '0; ev = '0;
      for (int i = 0; i < LANES; i++) begin
         a[i]  = real2sp(real'(i + 1));
         b[i]  = 32'h3F800000;
         ev[i] = real2sp(real'(i + 2));
      end
      expect_run(ev, LANES, FPU_LAT_ASM);
      drive_start(ADD, 4'(LANES + 3), a, b);
      wait_done("sat", 1'b0);

      // Stalled FPU: watchdog abort
      stall = 1'b1;
      et.vec = '0; et.err = 1'b1; et.lat = TIMEOUT + 1; et.en_cycles = TIMEOUT; et.gaps = 0;
      sb.push_back(et);
      drive_start(ADD, 4'd3, a, b);
      wait_done("timeout", 1'b0);
      stall = 1'b0;

      // Reset in the middle of element 1 of a DIV
      a = '0; b = '0;
      a[0] = 32'h40C00000; a[1] = 32'h40C00000;
      b[0] = 32'h40000000; b[1] = 32'h40000000;
      drive_start(DIV, 4'd2, a, b);
      repeat (24) @(negedge CLK);
      check("mid_div_elem0", bus.vec_o[31:0], 32'h40400000);
      check("mid_div_en", bus.fpu_enable, 1'b1);
      reset = 1'b0;
      #1;
      check("async_rst_en", bus.fpu_enable, 1'b0);
      @(negedge CLK);
      check("rst_mid_busy", bus.busy, 1'b0);
      check("rst_mid_done", bus.done, 1'b0);
      check("rst_mid_err", bus.err, 1'b0);
      check("rst_mid_vec_o", bus.vec_o, '0);
      check("rst_mid_en", bus.fpu_enable, 1'b0);
      check("rst_mid_fpu_a", bus.fpu_a, '0);
      reset = 1'b1;
      @(negedge CLK);

      a = '0; b = '0; ev = '0;
      a[0] = 32'h3F800000; a[1] = 32'h40000000;
      b[0] = 32'h3F800000; b[1] = 32'h3F800000;
      ev[0] = 32'h40000000; ev[1] = 32'h40400000;
      expect_run(ev, 2, FPU_LAT_ASM);
      drive_start(ADD, 4'd2, a, b);
      wait_done("add_after_rst", 1'b0);

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
